// File: rtl/first_nios2_system_sysid_checker.sv
// Avalon-MM reader that checks the sysid slave's ID and timestamp words against build-time values.
// Optional `SYSID_CHECK_CAPTURE_EN keeps the words read back on id_value/ts_value.
module first_nios2_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h56A5_18FD,
  parameter int unsigned TIMEOUT_CYCLES     = 16,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] stall_cnt;
  logic             launch;
  logic             id_accept;
  logic             ts_accept;

  // IDLE only exists right after reset, so AUTO_START launches from there unconditionally.
  assign launch    = ((state == IDLE) && (start | AUTO_START)) || ((state == DONE) && start);
  assign id_accept = (state == RD_ID) && !m_waitrequest;
  assign ts_accept = (state == RD_TS) && !m_waitrequest;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      stall_cnt <= '0;
      m_read    <= 1'b0;
      m_address <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            state     <= RD_ID;
            stall_cnt <= '0;
            m_read    <= 1'b1;
            m_address <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        RD_ID, RD_TS: begin
          if (!m_waitrequest) begin
            stall_cnt <= '0;
            if (state == RD_ID) begin
              id_ok     <= (m_readdata == EXPECTED_ID);
              m_address <= 1'b1;
              state     <= RD_TS;
            end else begin
              ts_ok     <= (m_readdata == EXPECTED_TIMESTAMP);
              m_read    <= 1'b0;
              m_address <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end else if (stall_cnt >= CNT_LAST) begin
            // This stall cycle is the TIMEOUT_CYCLES-th one: abandon the read.
            m_read    <= 1'b0;
            m_address <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            timeout   <= 1'b1;
            state     <= DONE;
          end else begin
            stall_cnt <= stall_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SYSID_CHECK_CAPTURE_EN
  logic [31:0] id_q;
  logic [31:0] ts_q;

  // Captured words are cleared when a new check launches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_q <= '0;
      ts_q <= '0;
    end else if (launch) begin
      id_q <= '0;
      ts_q <= '0;
    end else if (id_accept) begin
      id_q <= m_readdata;
    end else if (ts_accept) begin
      ts_q <= m_readdata;
    end
  end

  assign id_value = id_q;
  assign ts_value = ts_q;
`else
  logic unused_accept;
  assign unused_accept = id_accept ^ ts_accept;
  assign id_value = 32'h0;
  assign ts_value = 32'h0;
`endif

endmodule
